// File: rtl/fifo_write_packer_if.sv
// ---------------------------------------------------------------------------
// fifo_write_packer_if : serial input stream plus grouped FIFO write port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fifo_write_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 4,
  parameter int CNT_W      = $clog2(PAR_WRITE + 1)
);
  logic [DATA_WIDTH-1:0]                 in_data;
  logic                                  in_valid;
  logic                                  in_ready;
  logic                                  flush;
  logic [PAR_WRITE-1:0][DATA_WIDTH-1:0]  out_data;
  logic [CNT_W-1:0]                      out_count;
  logic                                  out_valid;
  logic                                  out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_count, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/fifo_write_packer.sv
// ---------------------------------------------------------------------------
// fifo_write_packer : packs serial words into PAR_WRITE-lane FIFO write groups
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_write_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 4,
  parameter int CNT_W      = $clog2(PAR_WRITE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_write_packer_if.slave    bus
);

  localparam int               IDX_W    = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_WRITE - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic [PAR_WRITE-1:0][DATA_WIDTH-1:0] lanes;
  logic [CNT_W-1:0]                     count;
  logic                                 in_ready_r;
  logic                                 out_valid_r;

  logic take;
  logic close_word;
  logic close_flush;

  // in_ready_r is only ever 1 in FILL, so it alone qualifies an input transfer
  assign take        = bus.in_valid && in_ready_r;
  assign close_word  = take && (bus.flush || (idx == LAST_IDX));
  assign close_flush = (state == FILL) && !take && bus.flush && (idx != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FILL;
      idx         <= '0;
      lanes       <= '0;
      count       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          for (int k = 0; k < PAR_WRITE; k++) begin
            if (take && (IDX_W'(k) == idx)) begin
              lanes[k] <= bus.in_data;
            end else if (close_word && (IDX_W'(k) > idx)) begin
              lanes[k] <= '0;
            end else if (close_flush && (IDX_W'(k) >= idx)) begin
              lanes[k] <= '0;
            end
          end

          if (close_word) begin
            count       <= CNT_W'(idx) + CNT_W'(1);
            state       <= HOLD;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end else if (close_flush) begin
            count       <= CNT_W'(idx);
            state       <= HOLD;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            in_ready_r  <= 1'b1;
            if (take) begin
              idx <= idx + 1'b1;
            end
          end
        end

        HOLD: begin
          // Group and count stay frozen until the FIFO takes them
          if (bus.out_ready) begin
            state       <= FILL;
            idx         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = lanes;
  assign bus.out_count = count;

endmodule

`default_nettype wire
